// File: rtl/bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_scanner
//  Description : Time-multiplexed registered BCD-to-decimal decoder. Holds a
//                packed word of DIGITS BCD digits and scans them one at a
//                time. For each digit it drives a one-hot decimal code and a
//                one-hot digit select, with invalid-code flags, optional
//                leading-zero blanking and a frame-complete strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [9:0]            out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [DIGITS-1:0]     err,
  output logic                  frame_done
);

  // Counter widths; a width of 1 is kept for the degenerate single-value case
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Held data and scan position
  logic [4*DIGITS-1:0] data_q;
  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;

  // Per-digit views of the held word
  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   err_next;

  // Selected-digit decode path
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [9:0]          dec;
  logic [DIGITS-1:0]   sel_next;
  logic                div_wrap;
  logic                idx_wrap;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign digit[i]    = data_q[4*i +: 4];
      // Flags are computed from the incoming word so they land with the load
      assign err_next[i] = (bcd_in[4*i +: 4] > 4'd9);
    end
  endgenerate

  // Leading-zero blanking: digit i>0 blanks when it and every digit above it
  // are zero. Invalid codes are non-zero, so they stop the blanking run.
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (|digit[i]);
      blank[i] = BLANK_LZ && (i != 0) && !nz;
    end
  end

  // Select the digit addressed by idx (explicit compare avoids out-of-range reads)
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = digit[i];
        cur_blank = blank[i];
      end
    end
  end

  // One-hot decimal decode; codes 10..15 match no output bit and give zero
  always_comb begin
    dec = '0;
    for (int d = 0; d < 10; d++) begin
      dec[d] = (cur_digit == 4'(d)) && !cur_blank;
    end
  end

  assign sel_next = DIGITS'(1) << idx;
  assign div_wrap = (div == DIV_LAST);
  assign idx_wrap = div_wrap && (idx == IDX_LAST);

  // Data and error-flag capture; load works whether or not scanning is enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      err    <= '0;
    end else if (load) begin
      data_q <= bcd_in;
      err    <= err_next;
    end
  end

  // Scan position: div paces each digit, idx steps through digits and wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (enable) begin
      if (div_wrap) begin
        div <= '0;
        idx <= idx_wrap ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Registered display outputs, reflecting idx/data_q from before the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else if (enable) begin
      out        <= dec;
      digit_sel  <= sel_next;
      frame_done <= idx_wrap;
    end else begin
      out        <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_digit_scanner
//  Description : Self-checking bench for bcd_digit_scanner. Two instances
//                share one stimulus stream: one with SCAN_DIV=4, no blanking,
//                and one with SCAN_DIV=1 and leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] bcd_in;

  logic [9:0]  out_a, out_b;
  logic [3:0]  sel_a, sel_b, err_a, err_b;
  logic        fd_a, fd_b;

  int total = 0;
  int bad   = 0;

  // Reference model: held word plus count of enabled cycles within a frame
  int m_data = 0;
  int m_pos [2] = '{0, 0};
  int sd    [2] = '{4, 1};
  int bl    [2] = '{0, 1};

  logic [9:0] e_out [2];
  logic [3:0] e_sel [2];
  logic       e_fd  [2];
  logic [3:0] e_err;

  always #5 clk = ~clk;

  bcd_digit_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in),
    .out(out_a), .digit_sel(sel_a), .err(err_a), .frame_done(fd_a)
  );

  bcd_digit_scanner #(.DIGITS(4), .SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in),
    .out(out_b), .digit_sel(sel_b), .err(err_b), .frame_done(fd_b)
  );

  // Expected decimal code of digit i of a held word
  function automatic logic [9:0] ref_digit(input int data, input int i, input int blz);
    int v;
    v = (data >> (4 * i)) & 15;
    if (v > 9) return 10'd0;
    if (blz != 0 && i > 0 && (data >> (4 * i)) == 0) return 10'd0;
    return 10'(1 << v);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input logic r, input logic en, input logic ld, input logic [15:0] b);
    rst    = r;
    enable = en;
    load   = ld;
    bcd_in = b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        e_out[k] = '0; e_sel[k] = '0; e_fd[k] = 1'b0; m_pos[k] = 0;
      end else if (en) begin
        int cur;
        cur      = m_pos[k] / sd[k];
        e_out[k] = ref_digit(m_data, cur, bl[k]);
        e_sel[k] = 4'(1 << cur);
        e_fd[k]  = (m_pos[k] == 4 * sd[k] - 1);
        m_pos[k] = (m_pos[k] + 1) % (4 * sd[k]);
      end else begin
        e_out[k] = '0; e_sel[k] = '0; e_fd[k] = 1'b0;
      end
    end
    if (r) begin
      m_data = 0;
      e_err  = '0;
    end else if (ld) begin
      m_data = int'(b);
      for (int i = 0; i < 4; i++) e_err[i] = (((int'(b) >> (4 * i)) & 15) > 9);
    end
    #1;
    check("out_a",        {6'b0, out_a},  {6'b0, e_out[0]});
    check("digit_sel_a",  {12'b0, sel_a}, {12'b0, e_sel[0]});
    check("err_a",        {12'b0, err_a}, {12'b0, e_err});
    check("frame_done_a", {15'b0, fd_a},  {15'b0, e_fd[0]});
    check("out_b",        {6'b0, out_b},  {6'b0, e_out[1]});
    check("digit_sel_b",  {12'b0, sel_b}, {12'b0, e_sel[1]});
    check("err_b",        {12'b0, err_b}, {12'b0, e_err});
    check("frame_done_b", {15'b0, fd_b},  {15'b0, e_fd[1]});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b1; bcd_in = 16'h1234;

    // Reset wins over load and enable
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 16'h1234);

    // First frame after reset shows zero on every digit
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Basic scan of 0x1937 across two full frames
    step(1'b0, 1'b1, 1'b1, 16'h1937);
    for (int n = 0; n < 34; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Invalid codes in digits 0 and 2
    step(1'b0, 1'b1, 1'b1, 16'h0A5F);
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Leading-zero patterns
    step(1'b0, 1'b1, 1'b1, 16'h0042);
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    for (int n = 0; n < 16; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Enable gap inside a digit, then a mid-digit load
    step(1'b0, 1'b1, 1'b1, 16'h1937);
    for (int n = 0; n < 16 && (m_pos[0] / 4) != 2; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h9999);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Reset in the middle of digit 3
    for (int n = 0; n < 16 && (m_pos[0] / 4) != 3; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Randomized traffic: enable gaps, loads (including invalid codes), resets
    for (int n = 0; n < 400; n++) begin
      logic r, en, ld;
      logic [15:0] b;
      r  = ($urandom % 60) == 0;
      en = ($urandom % 6) != 0;
      ld = ($urandom % 10) == 0;
      b  = 16'($urandom);
      step(r, en, ld, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
